instruction_fetch_unit: RTL and testbench

Fetch stage directly downstream of the 8-bit program counter. Holds a 256-entry instruction memory, reads the word addressed by the current PC, latches it into an instruction register, and presents it with a valid/ready handshake to the decode stage. It also issues a one-cycle step pulse so the PC advances only when an instruction has been accepted. It halts on the HALT opcode.

---
 rtl/instruction_fetch_unit_if.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode bundle for instruction_fetch_unit: run request, PC input,
// program-load write port, decode handshake and status outputs.
// Ports (slave = fetch unit view):
//   inputs : input_run, input_pc, input_wr_en, input_wr_addr, input_wr_data, input_ready
//   outputs: output_valid, output_instr, output_opcode, output_operand,
//            output_pc_step, output_halted, output_fetch_count
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OPCODE_WIDTH = 4
);

  logic                               input_run;
  logic [ADDR_WIDTH-1:0]              input_pc;
  logic                               input_wr_en;
  logic [ADDR_WIDTH-1:0]              input_wr_addr;
  logic [DATA_WIDTH-1:0]              input_wr_data;
  logic                               input_ready;
  logic                               output_valid;
  logic [DATA_WIDTH-1:0]              output_instr;
  logic [OPCODE_WIDTH-1:0]            output_opcode;
  logic [DATA_WIDTH-OPCODE_WIDTH-1:0] output_operand;
  logic                               output_pc_step;
  logic                               output_halted;
  logic [7:0]                         output_fetch_count;

  // Driver side: program loader, PC source and decode stage.
  modport master (
    output input_run, input_pc, input_wr_en, input_wr_addr, input_wr_data, input_ready,
    input  output_valid, output_instr, output_opcode, output_operand,
           output_pc_step, output_halted, output_fetch_count
  );

  // Fetch unit side.
  modport slave (
    input  input_run, input_pc, input_wr_en, input_wr_addr, input_wr_data, input_ready,
    output output_valid, output_instr, output_opcode, output_operand,
           output_pc_step, output_halted, output_fetch_count
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: 2^ADDR_WIDTH-word program memory read at the
// incoming PC, an instruction register presented to decode with valid/ready,
// a combinational PC step pulse on acceptance, and a sticky HALT state.
// Ports:
//   input_clk   - clock, rising edge
//   input_reset - asynchronous active-low reset
//   bus         - instruction_fetch_unit_if.slave (run, pc, load port,
//                 handshake, instruction fields, step, halted, fetch count)
// Build option: define IFU_FETCH_COUNT_EN to include the 8-bit accepted
// instruction counter; otherwise output_fetch_count is tied to zero.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input logic                     input_clk,
  input logic                     input_reset,
  instruction_fetch_unit_if.slave bus
);

  localparam int unsigned DEPTH         = 1 << ADDR_WIDTH;
  localparam int unsigned OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OP = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q;
  state_t                state_d;
  logic                  run_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic                  halted_q;
  logic                  accept_c;

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge input_clk) begin
    if (bus.input_wr_en) begin
      mem[bus.input_wr_addr] <= bus.input_wr_data;
    end
  end

  // Next-state and acceptance decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        accept_c = valid_q & bus.input_ready;
        if (accept_c) begin
          state_d = (instr_q[DATA_WIDTH-1 -: OPCODE_WIDTH] == HALT_OP) ? ST_HALT : ST_READ;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, registered run request, instruction register and status flags.
  // The run request is captured at one edge and acted on at the next, so
  // READ follows the sampling edge by one cycle.
  always_ff @(posedge input_clk or negedge input_reset) begin
    if (!input_reset) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= (state_q == ST_IDLE) & bus.input_run;
      valid_q  <= (state_d == ST_HOLD);
      halted_q <= (state_d == ST_HALT);
      // Read uses the pre-write memory value, so a same-edge write returns old data.
      if (state_q == ST_READ) begin
        instr_q <= mem[bus.input_pc];
      end
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [7:0] fetch_count_q;

  // Accepted-instruction counter, wraps naturally at 8 bits.
  always_ff @(posedge input_clk or negedge input_reset) begin
    if (!input_reset) begin
      fetch_count_q <= 8'h00;
    end else if (accept_c) begin
      fetch_count_q <= fetch_count_q + 8'd1;
    end
  end

  assign bus.output_fetch_count = fetch_count_q;
`else
  assign bus.output_fetch_count = 8'h00;
`endif

  assign bus.output_valid   = valid_q;
  assign bus.output_instr   = instr_q;
  assign bus.output_opcode  = instr_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign bus.output_operand = instr_q[OPERAND_WIDTH-1:0];
  assign bus.output_pc_step = accept_c;
  assign bus.output_halted  = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed programs push the
// expected instruction stream; a negedge monitor pops and compares on every
// accepted handshake.
module tb_instruction_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OPCODE_WIDTH(OW)) bus ();

  instruction_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OPCODE_WIDTH(OW)) u_dut (
    .input_clk   (clk),
    .input_reset (rst_n),
    .bus         (bus)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  count;
  } exp_t;

  exp_t sb_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   accepts     = 0;
  int   step_pulses = 0;
  int   exp_count   = 0;

  // PC model: steps on pc_step, or loads a directed value.
  logic [7:0] pc;
  logic       pc_load;
  logic [7:0] pc_load_val;
  assign bus.input_pc = pc;
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (bus.output_pc_step === 1'b1) pc <= pc + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input int c);
`ifdef IFU_FETCH_COUNT_EN
    return 8'(c);
`else
    return 8'h00;
`endif
  endfunction

  // Monitor: compare every accepted instruction against the scoreboard.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.output_pc_step === 1'b1) step_pulses++;
      if (bus.output_valid === 1'b1 && bus.input_ready === 1'b1) begin
        accepts++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_accept: got instr %0h expected none", bus.output_instr);
        end else begin
          e = sb_q.pop_front();
          check("mon_instr",   32'(bus.output_instr),       32'(e.instr));
          check("mon_opcode",  32'(bus.output_opcode),      32'(e.instr[15:12]));
          check("mon_operand", 32'(bus.output_operand),     32'(e.instr[11:0]));
          check("mon_count",   32'(bus.output_fetch_count), 32'(e.count));
          check("mon_step",    32'(bus.output_pc_step),     32'd1);
        end
      end else if (bus.output_pc_step !== 1'b0) begin
        check("step_without_accept", 32'(bus.output_pc_step), 32'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [15:0] d);
    bus.input_wr_en   = 1'b1;
    bus.input_wr_addr = a;
    bus.input_wr_data = d;
    tick();
    bus.input_wr_en   = 1'b0;
  endtask

  task automatic load_pc(input logic [7:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    tick();
    pc_load     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n     = 1'b1;
    exp_count = 0;
    tick();
  endtask

  task automatic expect_instr(input logic [15:0] d);
    sb_q.push_back({d, cnt_exp(exp_count)});
    exp_count++;
  endtask

  // Returns just after the edge that samples run.
  task automatic start_run();
    bus.input_run = 1'b1;
    tick();
    bus.input_run = 1'b0;
  endtask

  task automatic wait_halted(input int budget, input string name);
    int n = 0;
    while (bus.output_halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.output_halted), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (bus.output_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.output_valid), 32'd1);
  endtask

  initial begin
    int bad;
    int s0;
    int a0;
    rst_n             = 1'b0;
    pc_load           = 1'b0;
    pc_load_val       = 8'h00;
    bus.input_run     = 1'b0;
    bus.input_ready   = 1'b0;
    bus.input_wr_en   = 1'b0;
    bus.input_wr_addr = 8'h00;
    bus.input_wr_data = 16'h0000;

    // Reset state and idle behaviour.
    tick(2);
    check("rst_valid",   32'(bus.output_valid),       32'd0);
    check("rst_instr",   32'(bus.output_instr),       32'd0);
    check("rst_opcode",  32'(bus.output_opcode),      32'd0);
    check("rst_operand", 32'(bus.output_operand),     32'd0);
    check("rst_step",    32'(bus.output_pc_step),     32'd0);
    check("rst_halted",  32'(bus.output_halted),      32'd0);
    check("rst_count",   32'(bus.output_fetch_count), 32'd0);
    rst_n = 1'b1;
    bad   = 0;
    repeat (10) begin
      tick();
      if (bus.output_valid !== 1'b0 || bus.output_pc_step !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Basic fetch with latency checks, then HALT.
    write_mem(8'd0, 16'h1234);
    write_mem(8'd1, 16'hF000);
    load_pc(8'd0);
    bus.input_ready = 1'b1;
    expect_instr(16'h1234);
    expect_instr(16'hF000);
    s0 = step_pulses;
    start_run();
    check("lat_edge_n",   32'(bus.output_valid), 32'd0);
    tick();
    check("lat_read",     32'(bus.output_valid), 32'd0);
    tick();
    check("lat_valid",    32'(bus.output_valid),   32'd1);
    check("basic_instr",  32'(bus.output_instr),   32'h1234);
    check("basic_opcode", 32'(bus.output_opcode),  32'h1);
    check("basic_operand",32'(bus.output_operand), 32'h234);
    tick();
    check("basic_count1", 32'(bus.output_fetch_count), 32'(cnt_exp(1)));
    check("basic_step1",  32'(step_pulses - s0), 32'd1);
    wait_halted(20, "basic_halted");
    check("basic_halt_valid", 32'(bus.output_valid), 32'd0);

    // Backpressure: hold five cycles, then exactly one step on release.
    do_reset();
    bus.input_ready = 1'b0;
    write_mem(8'd3, 16'h5678);
    write_mem(8'd4, 16'hF000);
    load_pc(8'd3);
    expect_instr(16'h5678);
    expect_instr(16'hF000);
    start_run();
    wait_valid(10, "bp_valid");
    s0  = step_pulses;
    bad = 0;
    repeat (5) begin
      if (bus.output_valid !== 1'b1 || bus.output_instr !== 16'h5678 ||
          bus.output_pc_step !== 1'b0) bad++;
      tick();
    end
    check("bp_hold",    32'(bad), 32'd0);
    check("bp_no_step", 32'(step_pulses - s0), 32'd0);
    bus.input_ready = 1'b1;
    tick();
    check("bp_one_step", 32'(step_pulses - s0), 32'd1);
    wait_halted(20, "bp_halted");

    // Three-instruction program ending in HALT; run is ignored afterwards.
    do_reset();
    write_mem(8'd0, 16'h0001);
    write_mem(8'd1, 16'h0002);
    write_mem(8'd2, 16'hF000);
    load_pc(8'd0);
    bus.input_ready = 1'b1;
    expect_instr(16'h0001);
    expect_instr(16'h0002);
    expect_instr(16'hF000);
    a0 = accepts;
    start_run();
    wait_halted(30, "halt_reached");
    check("halt_accepts", 32'(accepts - a0), 32'd3);
    bus.input_run = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (bus.output_halted !== 1'b1 || bus.output_valid !== 1'b0) bad++;
    end
    bus.input_run = 1'b0;
    check("halt_sticky", 32'(bad), 32'd0);

    // Same-edge write and read of address 5 returns old data.
    do_reset();
    write_mem(8'd5, 16'h0AAA);
    write_mem(8'd6, 16'hF000);
    load_pc(8'd5);
    expect_instr(16'h0AAA);
    expect_instr(16'hF000);
    bus.input_run = 1'b1;
    tick();                 // run sampled
    bus.input_run = 1'b0;
    tick();                 // now in READ
    bus.input_wr_en   = 1'b1;
    bus.input_wr_addr = 8'd5;
    bus.input_wr_data = 16'h0BBB;
    tick();
    bus.input_wr_en   = 1'b0;
    check("collide_old", 32'(bus.output_instr), 32'h0AAA);
    wait_halted(20, "collide_halted");
    do_reset();
    load_pc(8'd5);
    expect_instr(16'h0BBB);
    expect_instr(16'hF000);
    start_run();
    wait_halted(20, "collide_new_halted");

    // Reset asserted mid-HOLD; memory must survive.
    do_reset();
    bus.input_ready = 1'b0;
    write_mem(8'd7, 16'h1111);
    write_mem(8'd8, 16'hF000);
    load_pc(8'd7);
    start_run();
    wait_valid(10, "midrst_hold");
    s0 = step_pulses;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.output_valid),   32'd0);
    check("midrst_step",  32'(bus.output_pc_step), 32'd0);
    check("midrst_instr", 32'(bus.output_instr),   32'd0);
    tick();
    rst_n     = 1'b1;
    exp_count = 0;
    tick();
    check("midrst_no_pulse", 32'(step_pulses - s0), 32'd0);
    load_pc(8'd7);
    bus.input_ready = 1'b1;
    expect_instr(16'h1111);
    expect_instr(16'hF000);
    start_run();
    wait_halted(20, "midrst_retained");

    // 256 acceptances wrap the counter back to zero.
    do_reset();
    bus.input_ready = 1'b0;
    for (int i = 0; i < 256; i++) write_mem(8'(i), 16'h0100 | 16'(i));
    load_pc(8'd0);
    bus.input_ready = 1'b1;
    for (int i = 0; i < 256; i++) expect_instr(16'h0100 | 16'(i));
    a0 = accepts;
    start_run();
    bad = 0;
    while (accepts < a0 + 256 && bad < 700) begin
      tick();
      bad++;
    end
    check("wrap_accepts", 32'(accepts - a0), 32'd256);
    check("count_wrap",   32'(bus.output_fetch_count), 32'(cnt_exp(256)));
    rst_n = 1'b0;
    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
